// File: rtl/ttc3_fuse_pkg.sv
// Shared types and widths for the TTC3 fuse sense path.
package ttc3_fuse_pkg;

  localparam int unsigned TTC3_FUSE_WORD_WIDTH = 32;
  localparam int unsigned TTC3_ID_WIDTH        = 128;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DONE,
    FAIL
  } fuse_state_t;

endpackage

// File: rtl/ttc3_fuse_loader.sv
// Boot-time OTP fuse reader: fetches ID words plus an XOR check word and
// publishes the ID only after it has been verified.
module ttc3_fuse_loader
  import ttc3_fuse_pkg::*;
#(
  parameter int unsigned ID_WIDTH       = TTC3_ID_WIDTH,
  parameter int unsigned WORD_WIDTH     = TTC3_FUSE_WORD_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned NW            = ID_WIDTH / WORD_WIDTH,
  localparam int unsigned ADDR_W        = $clog2(NW + 1),
  localparam int unsigned TMO_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  fuse_rd_req,
  output logic [ADDR_W-1:0]     fuse_rd_addr,
  input  logic                  fuse_rd_ack,
  input  logic [WORD_WIDTH-1:0] fuse_rd_data,
  output logic                  fuse_valid,
  output logic [ID_WIDTH-1:0]   fuse_id,
  output logic                  fuse_blank,
  output logic                  load_done,
  output logic                  load_error
);

  fuse_state_t           state;
  logic [TMO_W-1:0]      tmo_cnt;
  logic [WORD_WIDTH-1:0] acc;
  logic [ID_WIDTH-1:0]   stage;

  // fuse_rd_addr doubles as the word index; staging stays internal until verdict
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      fuse_rd_addr <= '0;
      tmo_cnt      <= '0;
      acc          <= '0;
      stage        <= '0;
      fuse_rd_req  <= 1'b0;
      fuse_valid   <= 1'b0;
      fuse_id      <= '0;
      fuse_blank   <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state        <= READ;
          fuse_rd_addr <= '0;
          tmo_cnt      <= '0;
          fuse_rd_req  <= 1'b1;
        end

        READ: begin
          if (fuse_rd_ack) begin
            tmo_cnt <= '0;
            if (fuse_rd_addr < ADDR_W'(NW)) begin
              for (int unsigned k = 0; k < NW; k++) begin
                if (fuse_rd_addr == ADDR_W'(k)) begin
                  stage[k*WORD_WIDTH +: WORD_WIDTH] <= fuse_rd_data;
                end
              end
              acc          <= acc ^ fuse_rd_data;
              fuse_rd_addr <= fuse_rd_addr + ADDR_W'(1);
            end else begin
              // Check word: decide the verdict at this edge
              fuse_rd_req <= 1'b0;
              load_done   <= 1'b1;
              if (stage == '0 && fuse_rd_data == '0) begin
                state      <= DONE;
                fuse_blank <= 1'b1;
              end else if ((acc ^ fuse_rd_data) == '0) begin
                state      <= DONE;
                fuse_id    <= stage;
                fuse_valid <= 1'b1;
              end else begin
                state      <= FAIL;
                load_error <= 1'b1;
              end
            end
          end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state       <= FAIL;
            fuse_rd_req <= 1'b0;
            load_done   <= 1'b1;
            load_error  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        default: ;  // DONE and FAIL hold until reset
      endcase
    end
  end

endmodule

// File: tb/tb_ttc3_fuse_loader.sv
// Directed, table-driven bench for ttc3_fuse_loader.
module tb_ttc3_fuse_loader;

  localparam int unsigned W   = 32;
  localparam int unsigned NW  = 4;
  localparam int unsigned IDW = 128;
  localparam int unsigned TMO = 16;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           fuse_rd_req;
  logic [2:0]     fuse_rd_addr;
  logic           fuse_rd_ack = 1'b0;
  logic [W-1:0]   fuse_rd_data = '0;
  logic           fuse_valid;
  logic [IDW-1:0] fuse_id;
  logic           fuse_blank;
  logic           load_done;
  logic           load_error;

  int n_checks = 0;
  int n_fail   = 0;
  int dly      = 0;

  typedef struct {
    logic [159:0] words;      // {check, w3, w2, w1, w0}
    int           stall_addr; // address never acked, -1 for none
    logic [127:0] exp_id;
    logic         exp_valid;
    logic         exp_blank;
    logic         exp_error;
    string        name;
  } vec_t;

  vec_t vecs[9];

  ttc3_fuse_loader #(
    .ID_WIDTH(IDW),
    .WORD_WIDTH(W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .fuse_rd_req(fuse_rd_req),
    .fuse_rd_addr(fuse_rd_addr),
    .fuse_rd_ack(fuse_rd_ack),
    .fuse_rd_data(fuse_rd_data),
    .fuse_valid(fuse_valid),
    .fuse_id(fuse_id),
    .fuse_blank(fuse_blank),
    .load_done(load_done),
    .load_error(load_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Fuse model: acks each request one cycle after it is seen
  task automatic respond(input logic [159:0] words, input int stall_addr);
    if (fuse_rd_req && int'(fuse_rd_addr) != stall_addr) begin
      if (dly >= 1) begin
        fuse_rd_ack  = 1'b1;
        fuse_rd_data = words[int'(fuse_rd_addr)*32 +: 32];
        dly = 0;
      end else begin
        fuse_rd_ack  = 1'b0;
        fuse_rd_data = '0;
        dly++;
      end
    end else begin
      fuse_rd_ack  = 1'b0;
      fuse_rd_data = '0;
      dly = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    fuse_rd_ack = 1'b0;
    fuse_rd_data = '0;
    dly = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic run_load(input vec_t v, input bit do_rst);
    int ack_cyc = -1;
    int done_cyc = -1;
    int stall_cnt = 0;
    int first_addr = -1;
    if (do_rst) do_reset();
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (load_done) begin
        done_cyc = c;
        break;
      end
      check({v.name, " pre_valid"}, 128'(fuse_valid), 128'(0));
      check({v.name, " pre_id"}, fuse_id, 128'(0));
      if (fuse_rd_req && first_addr < 0) first_addr = int'(fuse_rd_addr);
      if (fuse_rd_req && int'(fuse_rd_addr) == v.stall_addr) stall_cnt++;
      respond(v.words, v.stall_addr);
      if (fuse_rd_ack && fuse_rd_addr == 3'(NW)) ack_cyc = c;
    end
    fuse_rd_ack  = 1'b0;
    fuse_rd_data = '0;
    check({v.name, " done"}, 128'(load_done), 128'(1));
    check({v.name, " first_addr"}, 128'(first_addr), 128'(0));
    if (v.stall_addr < 0)
      check({v.name, " verdict_latency"}, 128'(done_cyc), 128'(ack_cyc + 1));
    else
      check({v.name, " stall_cycles"}, 128'(stall_cnt), 128'(TMO));
    check({v.name, " id"}, fuse_id, v.exp_id);
    check({v.name, " valid"}, 128'(fuse_valid), 128'(v.exp_valid));
    check({v.name, " blank"}, 128'(fuse_blank), 128'(v.exp_blank));
    check({v.name, " error"}, 128'(load_error), 128'(v.exp_error));
    check({v.name, " req_low"}, 128'(fuse_rd_req), 128'(0));
  endtask

  task automatic check_all_zero(input string name);
    check({name, " req"}, 128'(fuse_rd_req), 128'(0));
    check({name, " addr"}, 128'(fuse_rd_addr), 128'(0));
    check({name, " valid"}, 128'(fuse_valid), 128'(0));
    check({name, " id"}, fuse_id, 128'(0));
    check({name, " blank"}, 128'(fuse_blank), 128'(0));
    check({name, " done"}, 128'(load_done), 128'(0));
    check({name, " error"}, 128'(load_error), 128'(0));
  endtask

  initial begin
    logic [127:0] held_id;
    bit hit;

    vecs[0] = '{{32'h00000000, 32'h12345678, 32'h9ABCDEF0, 32'hFEDCBA98, 32'h76543210}, -1,
                128'h12345678_9ABCDEF0_FEDCBA98_76543210, 1'b1, 1'b0, 1'b0, "valid_id"};
    vecs[1] = '{{32'h00000001, 32'h12345678, 32'h9ABCDEF0, 32'hFEDCBA98, 32'h76543210}, -1,
                128'h0, 1'b0, 1'b0, 1'b1, "check_mismatch"};
    vecs[2] = '{160'h0, -1, 128'h0, 1'b0, 1'b1, 1'b0, "blank"};
    vecs[3] = '{{32'h00000000, 32'h12345678, 32'h9ABCDEF0, 32'hFEDCBA98, 32'h76543210}, 2,
                128'h0, 1'b0, 1'b0, 1'b1, "timeout_addr2"};
    vecs[4] = '{{32'h0000000F, 32'h00000008, 32'h00000004, 32'h00000002, 32'h00000001}, -1,
                128'h00000008_00000004_00000002_00000001, 1'b1, 1'b0, 1'b0, "valid_bits"};
    vecs[5] = '{{32'h00000001, 32'h0, 32'h0, 32'h0, 32'h0}, -1,
                128'h0, 1'b0, 1'b0, 1'b1, "zero_id_bad_check"};
    vecs[6] = '{{32'h00000000, 32'h0, 32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5}, -1,
                128'h00000000_00000000_A5A5A5A5_A5A5A5A5, 1'b1, 1'b0, 1'b0, "xor_zero_nonblank"};
    vecs[7] = '{{32'h00000000, 32'h12345678, 32'h9ABCDEF0, 32'hFEDCBA98, 32'h76543210}, 4,
                128'h0, 1'b0, 1'b0, 1'b1, "timeout_check_word"};
    vecs[8] = '{{32'h00000000, 32'h12345678, 32'h9ABCDEF0, 32'hFEDCBA98, 32'h76543210}, 0,
                128'h0, 1'b0, 1'b0, 1'b1, "timeout_addr0"};

    // Reset state
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_all_zero("reset");

    for (int i = 0; i < 9; i++) run_load(vecs[i], 1'b1);

    // Valid ID stays put, then spurious acks in DONE are ignored
    run_load(vecs[0], 1'b1);
    held_id = fuse_id;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("stable_id", fuse_id, vecs[0].exp_id);
      check("stable_valid", 128'(fuse_valid), 128'(1));
      check("stable_done", 128'(load_done), 128'(1));
    end
    fuse_rd_ack  = 1'b1;
    fuse_rd_data = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("spurious_id", fuse_id, held_id);
      check("spurious_valid", 128'(fuse_valid), 128'(1));
      check("spurious_error", 128'(load_error), 128'(0));
      check("spurious_req", 128'(fuse_rd_req), 128'(0));
    end
    fuse_rd_ack  = 1'b0;
    fuse_rd_data = '0;

    // Reset while address 2 is outstanding, then a clean reload
    do_reset();
    hit = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      if (fuse_rd_req && fuse_rd_addr == 3'd2) begin
        hit = 1'b1;
        break;
      end
      respond(vecs[0].words, -1);
    end
    check("midreset_reached_addr2", 128'(hit), 128'(1));
    reset = 1'b0;
    fuse_rd_ack = 1'b0;
    fuse_rd_data = '0;
    dly = 0;
    @(negedge clock);
    check_all_zero("midreset_1");
    @(negedge clock);
    check_all_zero("midreset_2");
    reset = 1'b1;
    run_load(vecs[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
